// File: rtl/uart_pkg.sv
// Shared constants and FSM state encodings for the 8N1 UART core.
package uart_pkg;
    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick: one-clk pulse every BAUD_DIV clks while enabled.
module uart_tick_gen #(
    parameter int BAUD_DIV = 54
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !en)                 cnt <= '0;
        else if (cnt == CW'(BAUD_DIV - 1)) cnt <= '0;
        else                               cnt <= cnt + 1'b1;
    end

    assign tick = en && (cnt == CW'(BAUD_DIV - 1));
endmodule

// File: rtl/uart_loopback_core.sv
// 8N1 UART transceiver: shared tick generator, TX FSM and RX FSM with a 2-flop input synchroniser.
module uart_loopback_core #(
    parameter int BAUD_DIV   = 54,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_gen_en,
    output logic       baud_tick,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_wire,
    input  logic       rx_wire,
    output logic [7:0] rx_data,
    output logic       rx_data_ready,
    output logic       rx_error
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    uart_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_tick (
        .clk(clk), .rst_n(rst_n), .en(baud_gen_en), .tick(baud_tick)
    );

    // ---------------- transmitter ----------------
    tx_state_t               tx_state, tx_state_nx;
    logic [CNT_W-1:0]        tx_cnt, tx_cnt_nx;
    logic [BIT_W-1:0]        tx_bit, tx_bit_nx;
    logic [DATA_BITS-1:0]    tx_shreg, tx_shreg_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_bit   <= tx_bit_nx;
            tx_shreg <= tx_shreg_nx;
        end
    end

    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_bit_nx   = tx_bit;
        tx_shreg_nx = tx_shreg;
        if (tx_state == TX_IDLE) begin
            // start is a per-clk check, so a held request restarts right after the idle cycle
            if (tx_start) begin
                tx_state_nx = TX_START;
                tx_shreg_nx = tx_data;
                tx_cnt_nx   = '0;
                tx_bit_nx   = '0;
            end
        end else if (baud_tick) begin
            tx_cnt_nx = tx_cnt + 1'b1;
            if (tx_cnt == CNT_W'(OVERSAMPLE - 1)) begin
                tx_cnt_nx = '0;
                case (tx_state)
                    TX_START: tx_state_nx = TX_DATA;
                    TX_DATA: begin
                        tx_shreg_nx = tx_shreg >> 1;
                        tx_bit_nx   = tx_bit + 1'b1;
                        if (tx_bit == BIT_W'(DATA_BITS - 1)) tx_state_nx = TX_STOP;
                    end
                    default:  tx_state_nx = TX_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        case (tx_state)
            TX_START: tx_wire = 1'b0;
            TX_DATA:  tx_wire = tx_shreg[0];
            default:  tx_wire = 1'b1;
        endcase
    end

    assign tx_busy = (tx_state != TX_IDLE);

    // ---------------- receiver ----------------
    logic rx_meta, rxs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_wire;
            rxs     <= rx_meta;
        end
    end

    rx_state_t               rx_state, rx_state_nx;
    logic [CNT_W-1:0]        rx_cnt, rx_cnt_nx;
    logic [BIT_W-1:0]        rx_bit, rx_bit_nx;
    logic [DATA_BITS-1:0]    rx_shreg, rx_shreg_nx, rx_data_nx;
    logic                    rx_rdy_nx, rx_err_nx;
    logic                    rx_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_shreg      <= '0;
            rx_data       <= '0;
            rx_data_ready <= 1'b0;
            rx_error      <= 1'b0;
        end else begin
            rx_state      <= rx_state_nx;
            rx_cnt        <= rx_cnt_nx;
            rx_bit        <= rx_bit_nx;
            rx_shreg      <= rx_shreg_nx;
            rx_data       <= rx_data_nx;
            rx_data_ready <= rx_rdy_nx;
            rx_error      <= rx_err_nx;
        end
    end

    assign rx_last = (rx_cnt == CNT_W'(OVERSAMPLE - 1));

    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt;
        rx_bit_nx   = rx_bit;
        rx_shreg_nx = rx_shreg;
        rx_data_nx  = rx_data;
        rx_rdy_nx   = 1'b0;
        rx_err_nx   = 1'b0;
        if (baud_tick) begin
            rx_cnt_nx = rx_cnt + 1'b1;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt_nx = '0;
                    if (!rxs) rx_state_nx = RX_START;
                end
                RX_START: if (rx_cnt == CNT_W'(MID_SAMPLE - 1)) begin
                    // re-anchor the counter at mid-bit so later samples land mid-bit too
                    rx_cnt_nx   = '0;
                    rx_bit_nx   = '0;
                    rx_state_nx = rxs ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_last) begin
                    rx_cnt_nx   = '0;
                    rx_shreg_nx = {rxs, rx_shreg[DATA_BITS-1:1]};
                    rx_bit_nx   = rx_bit + 1'b1;
                    if (rx_bit == BIT_W'(DATA_BITS - 1)) rx_state_nx = RX_STOP;
                end
                RX_STOP: if (rx_last) begin
                    rx_cnt_nx = '0;
                    if (rxs) begin
                        rx_data_nx  = rx_shreg;
                        rx_rdy_nx   = 1'b1;
                        rx_state_nx = RX_IDLE;
                    end else begin
                        rx_err_nx   = 1'b1;
                        rx_state_nx = RX_WAIT_HIGH;
                    end
                end
                RX_WAIT_HIGH: begin
                    rx_cnt_nx = '0;
                    if (rxs) rx_state_nx = RX_IDLE;
                end
                default: rx_state_nx = RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_loopback_core.sv
// Self-checking bench for uart_loopback_core: tick-timed line checks, byte scoreboard, corner sequences.
module tb_uart_loopback_core;
    localparam int BAUD_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n, baud_gen_en, baud_tick, tx_start, tx_busy, tx_wire, rx_wire;
    logic       rx_data_ready, rx_error, loop, rx_drv;
    logic [7:0] tx_data, rx_data;

    assign rx_wire = loop ? tx_wire : rx_drv;
    always #5 clk = ~clk;

    uart_loopback_core #(.BAUD_DIV(BAUD_DIV), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst_n(rst_n), .baud_gen_en(baud_gen_en), .baud_tick(baud_tick),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_wire(tx_wire),
        .rx_wire(rx_wire), .rx_data(rx_data), .rx_data_ready(rx_data_ready), .rx_error(rx_error)
    );

    int n_vec = 0, n_bad = 0;
    int tick_cnt = 0, rdy_cnt = 0, err_cnt = 0, gap = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_rx = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every ready pulse must deliver the next byte the bench expects
    always @(negedge clk) begin
        if (baud_tick) tick_cnt++;
        if (rx_error) err_cnt++;
        if (rx_data_ready) begin
            rdy_cnt++;
            chk("rdy_excl_err", 32'(rx_error), 0);
            if (exp_q.size() == 0) chk("unexpected_rdy", 32'(rx_data), -1);
            else chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic wait_tick(input int target);
        int guard = 0;
        while (tick_cnt < target && guard < 4000) begin
            @(negedge clk); #1;
            guard++;
        end
        if (tick_cnt < target) chk("tick_timeout", tick_cnt, target);
    endtask

    task automatic expect_rx(input logic [7:0] d);
        exp_q.push_back(d);
        last_rx = d;
    endtask

    // one TX frame; line sampled mid-bit, bit k spans ticks 16k+1..16k+16 after the start edge
    task automatic tx_frame(input logic [7:0] d, input logic [9:0] line, input int hold, input bit drive);
        int t0;
        int guard = 0;
        if (drive) begin
            @(negedge clk);
            tx_data  = d;
            tx_start = 1'b1;
        end else tx_data = d;
        gap = 0;
        do begin
            @(posedge clk); #1;
            gap++; guard++;
        end while (!tx_busy && guard < 2000);
        chk("tx_busy_rise", 32'(tx_busy), 1);
        t0 = tick_cnt;
        if (hold > 0) begin
            repeat (hold - 1) @(posedge clk);
            #1 tx_start = 1'b0;
        end
        tx_data = 8'($urandom);
        for (int k = 0; k < 10; k++) begin
            wait_tick(t0 + 16 * k + 8);
            chk($sformatf("tx_bit%0d", k), 32'(tx_wire), 32'(line[k]));
        end
        wait_tick(t0 + 160);
        chk("tx_busy_end", 32'(tx_busy), 1);
        @(posedge clk); #1;
        chk("tx_busy_fall", 32'(tx_busy), 0);
    endtask

    task automatic rx_frame(input logic [9:0] line);
        int t0;
        t0 = tick_cnt;
        for (int k = 0; k < 10; k++) begin
            rx_drv = line[k];
            wait_tick(t0 + 16 * (k + 1));
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         hold;
        logic [9:0] line;
        logic [7:0] exp_rx;
    } vec_t;
    vec_t tbl[4];

    initial begin
        int e0, r0, bad_tick, bad_hold;
        logic held;
        logic [7:0] d;

        tbl[0] = '{8'h55, 3, 10'b1010101010, 8'h55};
        tbl[1] = '{8'h00, 1, 10'b1000000000, 8'h00};
        tbl[2] = '{8'hFF, 2, 10'b1111111110, 8'hFF};
        tbl[3] = '{8'h81, 1, 10'b1100000010, 8'h81};

        rst_n = 1'b0; baud_gen_en = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
        loop = 1'b1; rx_drv = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_tx_wire", 32'(tx_wire), 1);
        chk("rst_tx_busy", 32'(tx_busy), 0);
        chk("rst_baud_tick", 32'(baud_tick), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_rx_rdy", 32'(rx_data_ready), 0);
        chk("rst_rx_err", 32'(rx_error), 0);
        @(negedge clk) rst_n = 1'b1;

        // table-driven loopback frames
        for (int i = 0; i < 4; i++) begin
            r0 = rdy_cnt;
            expect_rx(tbl[i].exp_rx);
            tx_frame(tbl[i].data, tbl[i].line, tbl[i].hold, 1'b1);
            chk("tbl_rdy_cnt", rdy_cnt - r0, 1);
            chk("tbl_err_cnt", err_cnt, 0);
        end

        // back-to-back with tx_start held: only the single IDLE cycle between frames
        r0 = rdy_cnt;
        expect_rx(8'hA5);
        expect_rx(8'h3C);
        tx_frame(8'hA5, 10'b1101001010, 0, 1'b1);
        tx_frame(8'h3C, 10'b1001111000, 1, 1'b0);
        chk("b2b_gap", gap, 1);
        chk("b2b_rdy_cnt", rdy_cnt - r0, 2);

        // randomized loopback against the frame model {stop, data, start}
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            expect_rx(d);
            tx_frame(d, {1'b1, d, 1'b0}, int'($urandom_range(1, 3)), 1'b1);
        end
        chk("rand_err_cnt", err_cnt, 0);

        // break: line low through the stop bit, then held low
        loop = 1'b0; rx_drv = 1'b1;
        wait_tick(tick_cnt + 4);
        e0 = err_cnt; r0 = rdy_cnt;
        rx_frame(10'b0000000000);
        wait_tick(tick_cnt + 48);
        chk("brk_err_cnt", err_cnt - e0, 1);
        chk("brk_rdy_cnt", rdy_cnt - r0, 0);
        chk("brk_rx_data_kept", 32'(rx_data), 32'(last_rx));
        rx_drv = 1'b1;
        wait_tick(tick_cnt + 4);
        expect_rx(8'h6B);
        rx_frame({1'b1, 8'h6B, 1'b0});
        wait_tick(tick_cnt + 4);
        chk("brk_recover_rdy", rdy_cnt - r0, 1);
        chk("brk_recover_err", err_cnt - e0, 1);

        // 4-tick glitch is a false start
        e0 = err_cnt; r0 = rdy_cnt;
        rx_drv = 1'b0;
        wait_tick(tick_cnt + 4);
        rx_drv = 1'b1;
        wait_tick(tick_cnt + 30);
        chk("glitch_rdy", rdy_cnt - r0, 0);
        chk("glitch_err", err_cnt - e0, 0);
        expect_rx(8'h5A);
        rx_frame({1'b1, 8'h5A, 1'b0});
        wait_tick(tick_cnt + 4);
        chk("glitch_recover_rdy", rdy_cnt - r0, 1);

        // tick generator paused mid-frame
        loop = 1'b1;
        r0 = rdy_cnt;
        expect_rx(8'hC3);
        bad_tick = 0; bad_hold = 0;
        fork
            tx_frame(8'hC3, 10'b1110000110, 2, 1'b1);
            begin
                wait_tick(tick_cnt + 48);
                @(posedge clk); #1;
                baud_gen_en = 1'b0;
                held = tx_wire;
                repeat (100) begin
                    @(negedge clk);
                    if (baud_tick) bad_tick++;
                    if (tx_wire != held) bad_hold++;
                end
                baud_gen_en = 1'b1;
            end
        join
        chk("pause_tick", bad_tick, 0);
        chk("pause_hold", bad_hold, 0);
        chk("pause_rdy", rdy_cnt - r0, 1);

        // reset in the middle of a frame
        e0 = err_cnt; r0 = rdy_cnt;
        @(negedge clk); tx_data = 8'h0F; tx_start = 1'b1;
        @(negedge clk); tx_start = 1'b0;
        wait_tick(tick_cnt + 50);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst_tx_wire", 32'(tx_wire), 1);
        chk("mrst_tx_busy", 32'(tx_busy), 0);
        chk("mrst_rx_data", 32'(rx_data), 0);
        chk("mrst_rx_rdy", 32'(rx_data_ready), 0);
        chk("mrst_rx_err", 32'(rx_error), 0);
        @(negedge clk) rst_n = 1'b1;
        wait_tick(tick_cnt + 40);
        chk("mrst_after_rdy", rdy_cnt - r0, 0);
        chk("mrst_after_err", err_cnt - e0, 0);
        chk("mrst_after_busy", 32'(tx_busy), 0);

        chk("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end
endmodule
